// File: rtl/cpack_match_engine.sv
// Two-stage dictionary match engine: stage 1 registers per-entry byte-match codes, stage 2 picks the best.
// Optional macro CPACK_ZERO_DETECT_EN flags all-zero words and keeps them out of the dictionary.
module cpack_match_engine #(
  parameter int DICT_ENTRY = 16,
  parameter int LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_word,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_word,
  output logic [1:0]        o_type,
  output logic [LOC_W-1:0]  o_location,
  output logic              o_zero,
  output logic [LOC_W:0]    o_dict_count
);

  logic [31:0]                 dict_q [DICT_ENTRY];
  logic [DICT_ENTRY-1:0]       dvld_q;
  logic [LOC_W-1:0]            wr_ptr_q;
  logic [LOC_W:0]              cnt_q;

  logic                        s1_vld_q;
  logic [31:0]                 s1_word_q;
  logic [DICT_ENTRY-1:0][1:0]  s1_code_q;

  logic                        out_vld_q;
  logic [31:0]                 out_word_q;
  logic [1:0]                  type_q;
  logic [LOC_W-1:0]            loc_q;

  logic                        adv1, adv2, accept, push, full_hit, in_zero;
  logic [DICT_ENTRY-1:0][1:0]  code_d;
  logic [DICT_ENTRY-1:0]       full_vec;
  logic [1:0]                  best_t;
  logic [LOC_W-1:0]            best_l;

  assign adv2       = ~out_vld_q | i_out_ready;
  assign adv1       = ~s1_vld_q | adv2;
  assign o_in_ready = adv1;
  assign accept     = i_in_valid & adv1;

`ifdef CPACK_ZERO_DETECT_EN
  logic s1_zero_q, zero_q;
  assign in_zero = (i_in_word == 32'd0);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_zero_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      if (accept)             s1_zero_q <= in_zero;
      if (adv2 && s1_vld_q)   zero_q    <= s1_zero_q;
    end
  end
  assign o_zero = zero_q;
`else
  assign in_zero = 1'b0;
  assign o_zero  = 1'b0;
`endif

  // Leading-byte match length from the MSB, one comparator per entry.
  for (genvar g = 0; g < DICT_ENTRY; g++) begin : g_cmp
    logic [3:0] eq;
    logic [1:0] code_raw;
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign eq[b] = (dict_q[g][8*b +: 8] == i_in_word[8*b +: 8]);
    end
    always_comb begin
      code_raw = 2'b00;
      if (dvld_q[g]) begin
        if (&eq)           code_raw = 2'b11;
        else if (&eq[3:1]) code_raw = 2'b10;
        else if (&eq[3:2]) code_raw = 2'b01;
      end
    end
    assign full_vec[g] = dvld_q[g] & (&eq);
    assign code_d[g]   = in_zero ? 2'b00 : code_raw;
  end

  assign full_hit = |full_vec;
  assign push     = accept & ~i_flush & ~full_hit & ~in_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dvld_q   <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (i_flush) begin
      dvld_q   <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (push) begin
      dvld_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q         <= wr_ptr_q + 1'b1;
      if (cnt_q != (LOC_W+1)'(DICT_ENTRY)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Entry data is qualified by dvld_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) dict_q[wr_ptr_q] <= i_in_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_vld_q  <= 1'b0;
      s1_word_q <= '0;
      s1_code_q <= '0;
    end else if (adv1) begin
      s1_vld_q <= i_in_valid;
      if (i_in_valid) begin
        s1_word_q <= i_in_word;
        s1_code_q <= code_d;
      end
    end
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_t = 2'b00;
    best_l = '0;
    for (int i = 0; i < DICT_ENTRY; i++) begin
      if (s1_code_q[i] > best_t) begin
        best_t = s1_code_q[i];
        best_l = LOC_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
      type_q     <= 2'b00;
      loc_q      <= '0;
    end else if (adv2) begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_word_q <= s1_word_q;
        type_q     <= best_t;
        loc_q      <= best_l;
      end
    end
  end

  assign o_out_valid  = out_vld_q;
  assign o_out_word   = out_word_q;
  assign o_type       = type_q;
  assign o_location   = loc_q;
  assign o_dict_count = cnt_q;

endmodule

// File: tb/tb_cpack_match_engine.sv
// Randomized and directed bench for cpack_match_engine against a queue-based dictionary model.
module tb_cpack_match_engine;
  localparam int DE = 16;
  localparam int LW = $clog2(DE);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [31:0]   in_word;
  logic          in_ready, out_valid, zero;
  logic [31:0]   out_word;
  logic [1:0]    typ;
  logic [LW-1:0] loc;
  logic [LW:0]   cnt;

  cpack_match_engine #(.DICT_ENTRY(DE)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_word(in_word),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_word(out_word),
    .o_type(typ), .o_location(loc), .o_zero(zero), .o_dict_count(cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic [1:0] t; int l; bit z; int age; } item_t;
  item_t       q[$];
  logic [31:0] mdict [DE];
  bit          mval  [DE];
  int          mptr, mcnt;
  bit          live = 0;
  int          checks = 0, errors = 0, hs = 0;
  logic [31:0] last_w;
  logic [1:0]  last_t;
  int          last_l;
  logic        last_z;
  logic [31:0] pool [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int e = 0; e < DE; e++) mval[e] = 0;
    mptr = 0;
    mcnt = 0;
  endfunction

  // Best match = longest leading-byte run; first entry wins among equals.
  function automatic void model_cmp(input logic [31:0] w, output logic [1:0] t, output int l,
                                    output bit z, output bit full);
    int n;
    logic [1:0] c;
    t = 0; l = 0; z = 0; full = 0;
`ifdef CPACK_ZERO_DETECT_EN
    if (w == 32'd0) begin z = 1; return; end
`endif
    for (int e = 0; e < DE; e++) begin
      if (mval[e]) begin
        n = 0;
        for (int b = 3; b >= 0; b--)
          if (n == 3 - b && w[8*b +: 8] == mdict[e][8*b +: 8]) n++;
        c = (n >= 2) ? 2'(n - 1) : 2'd0;
        if (c > t) begin t = c; l = e; end
        if (n == 4) full = 1;
      end
    end
  endfunction

  // Check at negedge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    bit exp_ov, exp_ir, zz, full;
    logic [1:0] tt;
    int ll;
    item_t it;
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    exp_ir = (q.size() < 2) || out_ready;
    if (live) begin
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, exp_ir);
      chk("dict_count", cnt, mcnt);
      if (exp_ov) begin
        chk("out_word", out_word, q[0].w);
        chk("type", typ, q[0].t);
        chk("location", loc, q[0].l);
        chk("zero", zero, q[0].z);
      end
    end
    if (rst) begin
      q.delete();
      model_clear();
      live = 1;
    end else if (live) begin
      if (exp_ov && out_ready) begin
        last_w = out_word; last_t = typ; last_l = int'(loc); last_z = zero;
        hs++;
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (in_valid && exp_ir) begin
        model_cmp(in_word, tt, ll, zz, full);
        it.w = in_word; it.t = tt; it.l = ll; it.z = zz; it.age = 0;
        q.push_back(it);
        if (!full && !zz && !flush) begin
          mdict[mptr] = in_word;
          mval[mptr]  = 1;
          mptr = (mptr + 1) % DE;
          if (mcnt < DE) mcnt++;
        end
      end
      if (flush) model_clear();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit fl);
    int h0, n;
    h0 = hs;
    in_valid = 1; in_word = w; flush = fl;
    tick();
    in_valid = 0; flush = 0;
    n = 0;
    while (hs == h0 && n < 20) begin tick(); n++; end
    if (hs == h0) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no result required=result for %08h", w);
    end
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
    tick();
  endtask

  initial begin
    int h0;
    logic [31:0] w;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_word = 0;
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_type", typ, 0);
    chk("rst_location", loc, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_zero", zero, 0);
    chk("rst_count", cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    send(32'h11223344, 0);
    chk("t1_type", last_t, 2'b00);
    chk("t1_loc", last_l, 0);
    chk("t1_count", cnt, 1);
    send(32'h11223344, 0);
    chk("t1b_type", last_t, 2'b11);
    chk("t1b_loc", last_l, 0);
    chk("t1b_count", cnt, 1);

    do_flush();
    send(32'hAABBCC00, 0);
    send(32'hAABBCCFF, 0);
    chk("t2_type", last_t, 2'b10);
    chk("t2_loc", last_l, 0);
    send(32'hAABB0000, 0);
    chk("t2b_type", last_t, 2'b01);
    chk("t2b_loc", last_l, 0);
    chk("t2_count", cnt, 3);

    do_flush();
    for (int i = 1; i <= 17; i++) send(32'(i) << 24, 0);
    chk("t3_count", cnt, 16);
    send(32'h01000000, 0);
    chk("t3_type", last_t, 2'b00);
    chk("t3_count2", cnt, 16);

    do_flush();
    send(32'h10000000, 0);
    send(32'h20000000, 0);
    send(32'h30000000, 0);
    send(32'hDEADBEEF, 0);
    chk("t4_count", cnt, 4);
    send(32'hDEADBEEF, 1);
    chk("t4_type", last_t, 2'b11);
    chk("t4_loc", last_l, 3);
    chk("t4_count", cnt, 0);

    send(32'h00000000, 0);
`ifdef CPACK_ZERO_DETECT_EN
    chk("t5_zero", last_z, 1);
    chk("t5_count", cnt, 0);
`else
    chk("t5_zero", last_z, 0);
    chk("t5_count", cnt, 1);
`endif
    chk("t5_type", last_t, 2'b00);

    h0 = hs;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_word = $urandom;
      tick();
    end
    chk("stall_in_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("stall_delivered", hs - h0, 2);

    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      w = pool[$urandom_range(0, 7)];
      case ($urandom_range(0, 4))
        1: w[7:0]  = 8'($urandom);
        2: w[15:0] = 16'($urandom);
        3: w[23:0] = 24'($urandom);
        4: w       = $urandom;
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) w = 32'd0;
      in_word   = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 511) == 0);
      tick();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (6) tick();
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
